clock_enable_divider: RTL and testbench

Parametrised multi-channel clock-enable generator that runs entirely on `refclk` and derives per-channel enable pulses and 50%-style divided clock outputs from runtime-programmable integer divisors. It is the RTL successor to the fixed single-output 50→25 MHz PLL divider: more channels, configurable ratios, glitch-free reconfiguration, phase realignment and a `locked` status. It sits between the board clock and downstream consumers (video timing, UART, sampling logic), which use `clk_en` as a qualifier in the `refclk` domain.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_channel.sv | 57 +++++
 rtl/clock_enable_divider.sv | 102 ++++++++++
 tb/tb_clock_enable_divider.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock-enable divider.
package clkdiv_pkg;

   localparam int unsigned CNT_W_DEF = 16;
   // Pending-slot field widths: up to 8 channels, divisors up to CNT_W_DEF bits.
   localparam int unsigned CH_W_MAX  = 3;

   typedef struct packed {
      logic [CH_W_MAX-1:0]  ch;
      logic [CNT_W_DEF-1:0] div;
   } cfg_t;

   function automatic int unsigned lock_w(input int unsigned lock_cycles);
      return (lock_cycles < 1) ? 1 : $clog2(lock_cycles + 1);
   endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: period counter, divisor register, apply-on-wrap and registered outputs.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned DIV_RESET = 2
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] new_div,
   input  logic             align,
   output logic             clk_en,
   output logic             outclk,
   output logic             applied
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             clk_en_q, clk_en_d;
   logic             outclk_q, outclk_d;
   logic             wrap;

   // A new divisor only lands at a period boundary (or a forced realign), so no runt periods.
   always_comb begin
      wrap     = (cnt_q == (div_q - CNT_W'(1)));
      applied  = load && (wrap || align);
      cnt_d    = cnt_q + CNT_W'(1);
      div_d    = div_q;
      clk_en_d = wrap;
      outclk_d = (cnt_q < (div_q >> 1));
      if (wrap || align || applied) begin
         cnt_d = '0;
      end
      if (applied) begin
         div_d = (new_div == '0) ? CNT_W'(1) : new_div;
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         div_q    <= CNT_W'(DIV_RESET);
         clk_en_q <= 1'b0;
         outclk_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         clk_en_q <= clk_en_d;
         outclk_q <= outclk_d;
      end
   end

   assign clk_en = clk_en_q;
   assign outclk = outclk_q;

endmodule

// File: rtl/clock_enable_divider.sv
// Multi-channel clock-enable generator: config handshake, single pending update slot and lock tracking.
module clock_enable_divider
   import clkdiv_pkg::*;
#(
   parameter  int unsigned NUM_CH      = 2,
   parameter  int unsigned CNT_W       = CNT_W_DEF,
   parameter  int unsigned DIV_RESET   = 2,
   parameter  int unsigned LOCK_CYCLES = 16,
   localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic              align,
   output logic [NUM_CH-1:0] clk_en,
   output logic [NUM_CH-1:0] outclk,
   output logic              locked
);

   localparam int unsigned LW = lock_w(LOCK_CYCLES);

   cfg_t              pend_q, pend_d;
   logic              pend_valid_q, pend_valid_d;
   logic              cfg_ready_q, cfg_ready_d;
   logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
   logic              locked_q, locked_d;
   logic              realign_q, realign_d;
   logic              align_eff, accept, drop, lock_clr, pend_live_d;
   logic [NUM_CH-1:0] load, applied;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = pend_valid_q && (32'(pend_q.ch) == 32'(i));

      clkdiv_channel #(
         .CNT_W     (CNT_W),
         .DIV_RESET (DIV_RESET)
      ) u_channel (
         .refclk  (refclk),
         .rst     (rst),
         .load    (load[i]),
         .new_div (CNT_W'(pend_q.div)),
         .align   (align_eff),
         .clk_en  (clk_en[i]),
         .outclk  (outclk[i]),
         .applied (applied[i])
      );
   end

   // An update captured together with align is applied by a second realign on the following edge.
   always_comb begin
      align_eff    = align || realign_q;
      accept       = cfg_valid && cfg_ready_q;
      drop         = pend_valid_q && (32'(pend_q.ch) >= 32'(NUM_CH));
      lock_clr     = (|applied) || align_eff;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if ((|applied) || drop) begin
         pend_valid_d = 1'b0;
      end
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_d.ch    = CH_W_MAX'(cfg_ch);
         pend_d.div   = CNT_W_DEF'(cfg_div);
      end
      pend_live_d = pend_valid_d && (32'(pend_d.ch) < 32'(NUM_CH));

      lock_cnt_d = lock_cnt_q;
      if (lock_clr) begin
         lock_cnt_d = '0;
      end else if (lock_cnt_q != LW'(LOCK_CYCLES)) begin
         lock_cnt_d = lock_cnt_q + LW'(1);
      end
      locked_d    = (lock_cnt_q == LW'(LOCK_CYCLES)) && !lock_clr && !pend_live_d;
      cfg_ready_d = !pend_valid_d;
      realign_d   = accept && align;
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         cfg_ready_q  <= 1'b1;
         lock_cnt_q   <= '0;
         locked_q     <= 1'b0;
         realign_q    <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         cfg_ready_q  <= cfg_ready_d;
         lock_cnt_q   <= lock_cnt_d;
         locked_q     <= locked_d;
         realign_q    <= realign_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_clock_enable_divider.sv
// Randomised and scenario bench for clock_enable_divider against a period-level reference model.
module tb_clock_enable_divider;

   localparam int unsigned NUM_CH    = 3;
   localparam int unsigned CNT_W     = 16;
   localparam int unsigned DIV_RESET = 2;
   localparam int unsigned LOCK      = 16;
   localparam int unsigned CH_W      = 2;

   logic              refclk = 1'b0;
   logic              rst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              align;
   logic [NUM_CH-1:0] clk_en;
   logic [NUM_CH-1:0] outclk;
   logic              locked;

   clock_enable_divider #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DIV_RESET   (DIV_RESET),
      .LOCK_CYCLES (LOCK)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .align     (align),
      .clk_en    (clk_en),
      .outclk    (outclk),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: each channel tracks its position within the current period.
   int              m_div [NUM_CH];
   int              m_ph  [NUM_CH];
   bit              m_pv, m_ready, m_locked, m_realign;
   int              m_pch, m_pdiv, m_lock;
   bit [NUM_CH-1:0] m_en, m_oc;

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_div[i] = DIV_RESET;
         m_ph[i]  = 0;
      end
      m_pv = 0; m_ready = 1; m_locked = 0; m_realign = 0;
      m_pch = 0; m_pdiv = 0; m_lock = 0;
      m_en = '0; m_oc = '0;
   endtask

   task automatic model_step(input bit v, input int ch, input int dv, input bit al);
      bit ae, acc, any_app, drop, clr, pv_next, wrap;
      ae      = al || m_realign;
      acc     = v && m_ready;
      any_app = 0;
      drop    = m_pv && (m_pch >= NUM_CH);
      for (int i = 0; i < NUM_CH; i++) begin
         wrap    = (m_ph[i] == m_div[i] - 1);
         m_en[i] = wrap;
         m_oc[i] = (m_ph[i] < m_div[i] / 2);
         if (m_pv && m_pch == i && (wrap || ae)) begin
            any_app  = 1;
            m_div[i] = (m_pdiv == 0) ? 1 : m_pdiv;
            m_ph[i]  = 0;
         end else if (wrap || ae) begin
            m_ph[i] = 0;
         end else begin
            m_ph[i] = m_ph[i] + 1;
         end
      end
      clr     = any_app || ae;
      pv_next = m_pv && !(any_app || drop);
      if (acc) begin
         pv_next = 1;
         m_pch   = ch;
         m_pdiv  = dv;
      end
      m_locked  = (m_lock == LOCK) && !clr && !(pv_next && m_pch < NUM_CH);
      m_lock    = clr ? 0 : ((m_lock < LOCK) ? m_lock + 1 : LOCK);
      m_pv      = pv_next;
      m_ready   = !m_pv;
      m_realign = acc && al;
   endtask

   task automatic compare_all();
      check("clk_en", 32'(clk_en), 32'(m_en));
      check("outclk", 32'(outclk), 32'(m_oc));
      check("locked", 32'(locked), 32'(m_locked));
      check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
   endtask

   // Drive one cycle of inputs, advance one edge, step the model and compare.
   task automatic cycle(input bit v, input int ch, input int dv, input bit al, output bit acc);
      cfg_valid = v;
      cfg_ch    = CH_W'(ch);
      cfg_div   = CNT_W'(dv);
      align     = al;
      acc       = v && m_ready;
      @(posedge refclk);
      model_step(v, ch, dv, al);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      bit a;
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, a);
   endtask

   task automatic send(input int ch, input int dv);
      bit acc = 0;
      bit a;
      for (int n = 0; n < 40 && !acc; n++) begin
         cycle(1, ch, dv, 0, a);
         acc = a;
      end
      check("send_accepted", 32'(acc), 32'd1);
   endtask

   initial begin
      bit a;
      int t1, t2, nseen;
      bit req;
      int rch, rdv;

      rst = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; align = 0;
      model_reset();
      repeat (2) @(posedge refclk);
      #1;
      check("rst_clk_en", 32'(clk_en), 32'd0);
      check("rst_outclk", 32'(outclk), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      rst = 1;

      // Defaults: divide by two, lock after 17 edges.
      for (int k = 1; k <= 20; k++) begin
         cycle(0, 0, 0, 0, a);
         if (k == 1) check("first_clk_en_low", 32'(clk_en), 32'd0);
         if (k == 2) check("first_clk_en_high", 32'(clk_en), 32'h7);
         if (k == 16) check("locked_before", 32'(locked), 32'd0);
         if (k == 17) check("locked_rise", 32'(locked), 32'd1);
      end

      // ch1 to divide-by-5, then measure its enable period.
      send(1, 5);
      idle(25);
      nseen = 0; t1 = 0; t2 = 0;
      for (int k = 0; k < 20 && nseen < 2; k++) begin
         cycle(0, 0, 0, 0, a);
         if (clk_en[1]) begin
            if (nseen == 0) t1 = k; else t2 = k;
            nseen++;
         end
      end
      check("ch1_period", 32'(t2 - t1), 32'd5);

      // Back-to-back updates: second is held off until the first applies.
      send(0, 3);
      send(1, 4);
      idle(20);

      // Realign: ch0 (/3) and ch1 (/4) coincide 12 edges after align.
      cycle(0, 0, 0, 1, a);
      for (int k = 1; k <= 12; k++) begin
         cycle(0, 0, 0, 0, a);
         if (k == 12) check("align_coincide", 32'(clk_en[1:0]), 32'h3);
      end
      idle(20);

      // Divisors 0 and 1 behave identically; out-of-range channel is dropped.
      send(2, 0);
      idle(6);
      send(0, 1);
      idle(6);
      send(3, 7);
      idle(20);

      // Asynchronous reset with an update pending on ch1.
      send(1, 9);
      check("pending_before_rst", 32'(cfg_ready), 32'd0);
      rst = 0;
      #2;
      check("midrst_clk_en", 32'(clk_en), 32'd0);
      check("midrst_outclk", 32'(outclk), 32'd0);
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
      model_reset();
      @(posedge refclk);
      #1;
      rst = 1;
      idle(24);

      // Randomised traffic with a master that holds requests until accepted.
      req = 0; rch = 0; rdv = 0;
      for (int k = 0; k < 2000; k++) begin
         if (!req && ($urandom % 4 == 0)) begin
            req = 1;
            rch = int'($urandom % 4);
            rdv = int'($urandom % 10);
         end
         cycle(req, rch, rdv, ($urandom % 40) == 0, a);
         if (a) req = 0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
